// File: rtl/a0_logger_pkg.sv
// Shared types and constants for the a0 change-capture logger.
package a0_logger_pkg;

    localparam int LOG_DATA_W = 32;
    localparam int LOG_TS_W   = 16;

    localparam int                DROP_W   = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    // Host-side view of one logged entry at the default widths.
    typedef struct packed {
        logic [LOG_TS_W-1:0]   ts;
        logic [LOG_DATA_W-1:0] data;
    } log_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with explicit occupancy count and a zeroed head when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             pop_ok;
    logic             push_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/a0_logger.sv
// Logs each new value of the cpu a0 register with a cycle timestamp into a FIFO,
// tracking overflow and a saturating count of dropped entries.
module a0_logger
    import a0_logger_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TS_WIDTH   = 16,
    parameter int DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [DATA_WIDTH-1:0]   a0,
    input  logic                    clr_overflow,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [TS_WIDTH-1:0]     out_ts,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic [DROP_W-1:0]       drop_cnt
);

    typedef struct packed {
        logic [TS_WIDTH-1:0]   ts;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == DROP_MAX) ? v : v + 1'b1;
    endfunction

    logic [TS_WIDTH-1:0]   ts_q, ts_d;
    logic [DATA_WIDTH-1:0] prev_q;
    logic                  primed_q;
    logic                  overflow_q, overflow_d;
    logic [DROP_W-1:0]     drop_cnt_q, drop_cnt_d;

    logic                  push_req;
    logic                  pop_req;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  drop;
    entry_t                wr_entry;
    entry_t                rd_entry;

    // The first enabled cycle after reset always logs, whatever a0 holds.
    assign push_req = en && (!primed_q || (a0 != prev_q));
    assign pop_req  = out_valid && out_ready;
    assign drop     = push_req && fifo_full && !pop_req;

    assign wr_entry = '{ts: ts_q, data: a0};

    always_comb begin
        ts_d       = ts_q + 1'b1;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        // A drop in the clearing cycle survives the clear as the first new drop.
        if (drop) begin
            overflow_d = 1'b1;
            drop_cnt_d = clr_overflow ? DROP_W'(1) : sat_inc(drop_cnt_q);
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q       <= '0;
            prev_q     <= '0;
            primed_q   <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            if (en) begin
                prev_q   <= a0;
                primed_q <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (push_req),
        .pop_i   (pop_req),
        .wdata_i (wr_entry),
        .rdata_o (rd_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = rd_entry.data;
    assign out_ts    = rd_entry.ts;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: doc/a0_logger.md
# a0_logger

Change-capture logger sitting directly downstream of `cpu`, consuming its `a0` result register. Each time `a0` takes a new value while capture is enabled, the block records the value together with a free-running cycle timestamp in a small FIFO. It presents entries on a valid/ready stream to the host/display side, and it reports overflow and dropped-entry counts so that bursty `a0` activity (e.g. tight counter loops) is never silently lost.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of `a0` and of logged values
- `TS_WIDTH`, 16, timestamp counter width
- `DEPTH`, 8, FIFO entries; power of two, ≥2

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset: asynchronous, active-low
- `en`  in  1  capture enable
- `a0`  in  DATA_WIDTH  `cpu` a0 output
- `clr_overflow`  in  1  clears `overflow` and `drop_cnt`
- `out_ready`  in  1  consumer accepts head entry
- `out_valid`  out  1  FIFO non-empty
- `out_data`  out  DATA_WIDTH  head entry value
- `out_ts`  out  TS_WIDTH  head entry timestamp
- `count`  out  $clog2(DEPTH)+1  entries held
- `overflow`  out  1  sticky, entry dropped
- `drop_cnt`  out  8  dropped entries, saturating

## Operation
- Timestamp `ts`: increments every cycle; wraps `2^TS_WIDTH-1 → 0`; runs regardless of `en`.
- Change detect: registers `prev` (last sampled a0) and `primed` (0 after reset). Push request in a cycle when `en && (!primed || a0 != prev)`. When `en=1`, `prev<=a0` and `primed<=1`. When `en=0`, neither updates, so re-enabling compares against the last value seen while enabled.
- Pushed entry = {current `ts`, current `a0`}, sampled in the request cycle.
- Pop: when `out_valid && out_ready`.
- Push with FIFO not full, or full with a pop in the same cycle: accepted. When full, the count stays at `DEPTH`.
- Push while full with no pop: dropped. `overflow<=1`, `drop_cnt` increments, saturating at 255.
- `clr_overflow`: clears both flags. If a drop occurs in the same cycle, the drop wins: `overflow=1`, `drop_cnt=1`.
- Pop request while empty: ignored. Push and pop in the same cycle while empty: push only; no bypass.
- Read/write pointers are `$clog2(DEPTH)` bits and wrap naturally. `count` is tracked explicitly (0..DEPTH).

## Timing
- Reset (async assert, release synchronous to `clk`) sets the following to 0: `ts`, `prev`, `primed`, pointers, `count`, `out_valid`, `out_data`, `out_ts`, `overflow`, `drop_cnt`.
- Latency: push request in cycle N gives `count`/`out_valid` updated after edge N+1, with the entry visible at the head if the FIFO was empty.
- `out_data`/`out_ts` are the head of the FIFO storage. They are stable while `out_valid=1 && out_ready=0`.
- After a pop at edge N+1, the next entry (or `out_valid=0`) appears after that edge. Full throughput is one entry per cycle.
- Reset asserted mid-stream discards all entries immediately. The first enabled cycle after release always pushes.

## Structure
- Package `a0_logger_pkg`: `log_entry_t` packed struct {ts, data}, drop-counter width constant `DROP_W=8`, and saturation max.
- Sub-module `sync_fifo` (parameterised width/depth, push/pop/full/empty/count, async active-low reset). The top level holds the change detector, timestamp counter, and overflow logic.
- Instantiated alongside `cpu` at the top level, with `a0` wired directly.

## Test plan
- Reset release, `en=1`, a0 held 0 for 5 cycles → exactly one entry {ts=0, data=0}; `count=1`.
- a0 sequence 5,5,7,7,9 with `out_ready=1`, starting at ts=10 → entries (10,5),(12,7),(14,9), each appearing one cycle after its change; `count` never exceeds 1.
- `out_ready=0`, a0 changes 10 times, DEPTH=8 → `count=8`, `overflow=1`, `drop_cnt=2`, head is first value. Then `clr_overflow` with a simultaneous drop → `overflow=1`, `drop_cnt=1`.
- Full FIFO, `out_ready=1`, and a new a0 change in the same cycle → pop and push both occur; `count` stays 8; no drop.
- `en=0` while a0 changes 3→4→3, then `en=1` with a0=3 (prev=3) → no push. Then a0=8 → one push.
- Timestamp wrap with TS_WIDTH=4: change at cycle 17 after reset → `out_ts=1`. Async reset mid-stream with `count=5` → `count=0` and `out_valid=0` without waiting for a clock edge.
